// File: rtl/ipv4_hdr_pkg.sv
// Shared types and helpers for the IPv4 header serializer.
// State encoding, header geometry constants and the header-word packing function.
package ipv4_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHK_WAIT = 2'd1,
    SEND     = 2'd2
  } state_t;

  localparam logic [15:0] IPV4_VER_IHL   = 16'h4500;
  localparam int          IPV4_HDR_WORDS = 10;
  localparam int          IPV4_HDR_BYTES = 20;

  // Word k lands at bits [16k+15:16k]; the checksum word (5) is packed as zero.
  function automatic logic [16*IPV4_HDR_WORDS-1:0] pack_hdr_words(
    input logic [15:0] total_len,
    input logic [15:0] ident,
    input logic        df,
    input logic [7:0]  ttl,
    input logic [7:0]  protocol,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip
  );
    return {dst_ip[15:0], dst_ip[31:16], src_ip[15:0], src_ip[31:16],
            16'h0000, ttl, protocol, 1'b0, df, 14'd0, ident, total_len,
            IPV4_VER_IHL};
  endfunction

endpackage

// File: rtl/ipv4_header_serializer.sv
// IPv4 header serializer: hands 10 header words to an external checksum stage, then streams 20 bytes.
// Build option IPV4_HDR_ID_COUNTER_EN replaces the ident port with an internal per-header ID counter.
module ipv4_header_serializer
  import ipv4_hdr_pkg::*;
#(
  parameter int unsigned C_CHK_LATENCY = 11,
  parameter bit          C_DF          = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [15:0]  total_len,
  input  logic [15:0]  ident,
  input  logic [7:0]   ttl,
  input  logic [7:0]   protocol,
  input  logic [31:0]  src_ip,
  input  logic [31:0]  dst_ip,
  output logic         chk_trigger,
  output logic [159:0] chk_values,
  input  logic [15:0]  chk_checksum,
  output logic [7:0]   m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast
);

  localparam logic [7:0] LP_LATENCY  = 8'(C_CHK_LATENCY);
  localparam logic [4:0] LP_LAST_IDX = 5'(IPV4_HDR_BYTES - 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [7:0]     r_wait_cnt;
  logic [4:0]     r_idx;
  logic [15:0]    r_checksum;
  logic [159:0]   r_values;
  logic           r_trigger;
  logic           r_tvalid;
  logic [7:0]     r_tdata;
  logic           r_tlast;
  logic [15:0]    w_ident;
  logic           w_accept;
  logic           w_capture;
  logic           w_hs;
  logic           w_last_hs;
  logic [4:0]     w_idx_next;

  // Word 5 is served from the captured checksum instead of the zero word sent to the checksum stage.
  function automatic logic [7:0] hdr_byte(
    input logic [159:0] words,
    input logic [15:0]  csum,
    input logic [4:0]   idx
  );
    logic [15:0] w;
    w = (idx[4:1] == 4'd5) ? csum : words[{idx[4:1], 4'b0000} +: 16];
    return idx[0] ? w[7:0] : w[15:8];
  endfunction

  assign w_accept   = (r_state == IDLE) && start;
  assign w_capture  = (r_state == CHK_WAIT) && (r_wait_cnt == 8'd0);
  assign w_hs       = r_tvalid && m_axis_tready;
  assign w_last_hs  = w_hs && r_tlast;
  assign w_idx_next = r_idx + 5'd1;

`ifdef IPV4_HDR_ID_COUNTER_EN
  logic [15:0] r_id_cnt;
  logic        w_unused_ident;

  assign w_unused_ident = ^ident;
  assign w_ident        = r_id_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_cnt <= 16'd0;
    end else if (w_last_hs) begin
      r_id_cnt <= r_id_cnt + 16'd1;
    end
  end
`else
  assign w_ident = ident;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (start)      w_state_next = CHK_WAIT;
      CHK_WAIT: if (w_capture)  w_state_next = SEND;
      SEND:     if (w_last_hs)  w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
      r_values   <= '0;
      r_trigger  <= 1'b0;
    end else begin
      r_trigger <= w_accept;
      if (w_accept) begin
        r_values   <= pack_hdr_words(total_len, w_ident, C_DF, ttl, protocol,
                                     src_ip, dst_ip);
        r_wait_cnt <= LP_LATENCY;
      end else if ((r_state == CHK_WAIT) && (r_wait_cnt != 8'd0)) begin
        r_wait_cnt <= r_wait_cnt - 8'd1;
      end
    end
  end

  // tdata is registered one byte ahead so it is already stable when tvalid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 16'd0;
      r_idx      <= 5'd0;
      r_tvalid   <= 1'b0;
      r_tdata    <= 8'd0;
      r_tlast    <= 1'b0;
    end else if (w_capture) begin
      r_checksum <= chk_checksum;
      r_idx      <= 5'd0;
      r_tvalid   <= 1'b1;
      r_tdata    <= hdr_byte(r_values, chk_checksum, 5'd0);
      r_tlast    <= 1'b0;
    end else if (w_hs) begin
      if (r_tlast) begin
        r_idx    <= 5'd0;
        r_tvalid <= 1'b0;
        r_tdata  <= 8'd0;
        r_tlast  <= 1'b0;
      end else begin
        r_idx   <= w_idx_next;
        r_tdata <= hdr_byte(r_values, r_checksum, w_idx_next);
        r_tlast <= (w_idx_next == LP_LAST_IDX);
      end
    end
  end

  assign ready         = (r_state == IDLE);
  assign chk_trigger   = r_trigger;
  assign chk_values    = r_values;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule
